// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types, constants and address check for the imem arbiter
package imem_pkg;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } arb_state_t;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // Word-aligned and inside the array; the array is indexed by addr>>2.
    function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth);
    endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// rtl/imem_arbiter_if.sv - fetch, loader and memory-side signal bundle
interface imem_arbiter_if;
    logic        fetch_valid;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic        fetch_rsp_valid;
    logic [31:0] fetch_rsp_data;
    logic        fetch_rsp_err;

    logic        ldr_valid;
    logic        ldr_we;
    logic [31:0] ldr_addr;
    logic [31:0] ldr_wdata;
    logic        ldr_done;
    logic        ldr_ready;
    logic        ldr_rsp_valid;
    logic [31:0] ldr_rsp_data;
    logic        ldr_rsp_err;

    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        running;

    modport slave (
        input  fetch_valid, fetch_addr,
        input  ldr_valid, ldr_we, ldr_addr, ldr_wdata, ldr_done,
        input  mem_rdata,
        output fetch_ready, fetch_rsp_valid, fetch_rsp_data, fetch_rsp_err,
        output ldr_ready, ldr_rsp_valid, ldr_rsp_data, ldr_rsp_err,
        output mem_addr, mem_we, mem_wdata,
        output running
    );

    modport master (
        output fetch_valid, fetch_addr,
        output ldr_valid, ldr_we, ldr_addr, ldr_wdata, ldr_done,
        output mem_rdata,
        input  fetch_ready, fetch_rsp_valid, fetch_rsp_data, fetch_rsp_err,
        input  ldr_ready, ldr_rsp_valid, ldr_rsp_data, ldr_rsp_err,
        input  mem_addr, mem_we, mem_wdata,
        input  running
    );
endinterface

// File: rtl/imem_rr_fair.sv
// rtl/imem_rr_fair.sv - fetch-priority grant with a loader fairness counter
module imem_rr_fair #(
    parameter int unsigned FAIR_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    input  logic fetch_valid_i,
    input  logic ldr_valid_i,
    output logic fetch_gnt_o,
    output logic ldr_gnt_o
);

    logic [3:0] fair_cnt_q;
    logic [3:0] fair_cnt_d;
    logic       starved;

    assign starved = (fair_cnt_q == 4'(FAIR_LIMIT));

    always_comb begin
        fetch_gnt_o = 1'b0;
        ldr_gnt_o   = 1'b0;
        if (!run_i) begin
            ldr_gnt_o = ldr_valid_i;
        end else if (ldr_valid_i && (starved || !fetch_valid_i)) begin
            ldr_gnt_o = 1'b1;
        end else begin
            fetch_gnt_o = fetch_valid_i;
        end
    end

    // Counts only fetch wins that made the loader wait.
    always_comb begin
        fair_cnt_d = fair_cnt_q;
        if (ldr_gnt_o || !ldr_valid_i) begin
            fair_cnt_d = 4'd0;
        end else if (fetch_gnt_o && !starved) begin
            fair_cnt_d = fair_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fair_cnt_q <= 4'd0;
        end else begin
            fair_cnt_q <= fair_cnt_d;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - boot/run scheduler sharing one instruction memory
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned FAIR_LIMIT = 4,
    parameter logic [31:0] NOP_INSN   = imem_pkg::NOP_INSN
) (
    input  logic           clk,
    input  logic           rst,
    imem_arbiter_if.slave  bus
);

    arb_state_t  state_q, state_d;
    logic        fetch_gnt_raw, ldr_gnt_raw;
    logic        fetch_gnt, ldr_gnt;
    logic        fetch_ok, ldr_ok;
    logic [31:0] mem_addr_q, mem_addr_d;

    logic        fetch_rsp_valid_q, fetch_rsp_err_q;
    logic [31:0] fetch_rsp_data_q;
    logic        ldr_rsp_valid_q, ldr_rsp_err_q;
    logic [31:0] ldr_rsp_data_q;

    imem_rr_fair #(
        .FAIR_LIMIT (FAIR_LIMIT)
    ) u_fair (
        .clk           (clk),
        .rst           (rst),
        .run_i         (state_q == RUN),
        .fetch_valid_i (bus.fetch_valid),
        .ldr_valid_i   (bus.ldr_valid),
        .fetch_gnt_o   (fetch_gnt_raw),
        .ldr_gnt_o     (ldr_gnt_raw)
    );

    // Grants are masked while reset is held so ready/mem_we clear immediately.
    assign fetch_gnt = fetch_gnt_raw & ~rst;
    assign ldr_gnt   = ldr_gnt_raw & ~rst;

    assign fetch_ok = addr_ok(bus.fetch_addr, IMEM_DEPTH);
    assign ldr_ok   = addr_ok(bus.ldr_addr, IMEM_DEPTH);

    always_comb begin
        state_d = state_q;
        if (state_q == BOOT && bus.ldr_done) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        mem_addr_d = mem_addr_q;
        if (ldr_gnt) begin
            mem_addr_d = bus.ldr_addr;
        end else if (fetch_gnt) begin
            mem_addr_d = bus.fetch_addr;
        end
    end

    assign bus.mem_addr    = mem_addr_d;
    assign bus.mem_we      = ldr_gnt & bus.ldr_we & ldr_ok;
    assign bus.mem_wdata   = bus.ldr_wdata;
    assign bus.fetch_ready = fetch_gnt;
    assign bus.ldr_ready   = ldr_gnt;
    assign bus.running     = (state_q == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr_q        <= 32'd0;
            fetch_rsp_valid_q <= 1'b0;
            fetch_rsp_err_q   <= 1'b0;
            fetch_rsp_data_q  <= 32'd0;
            ldr_rsp_valid_q   <= 1'b0;
            ldr_rsp_err_q     <= 1'b0;
            ldr_rsp_data_q    <= 32'd0;
        end else begin
            mem_addr_q        <= mem_addr_d;
            fetch_rsp_valid_q <= fetch_gnt;
            ldr_rsp_valid_q   <= ldr_gnt;
            if (fetch_gnt) begin
                fetch_rsp_err_q  <= ~fetch_ok;
                fetch_rsp_data_q <= fetch_ok ? bus.mem_rdata : NOP_INSN;
            end
            if (ldr_gnt) begin
                ldr_rsp_err_q  <= ~ldr_ok;
                ldr_rsp_data_q <= (bus.ldr_we || !ldr_ok) ? 32'd0 : bus.mem_rdata;
            end
        end
    end

    assign bus.fetch_rsp_valid = fetch_rsp_valid_q;
    assign bus.fetch_rsp_data  = fetch_rsp_data_q;
    assign bus.fetch_rsp_err   = fetch_rsp_err_q;
    assign bus.ldr_rsp_valid   = ldr_rsp_valid_q;
    assign bus.ldr_rsp_data    = ldr_rsp_data_q;
    assign bus.ldr_rsp_err     = ldr_rsp_err_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - directed self-checking bench for imem_arbiter
module tb_imem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [31:0] DA = 32'hA0A0_0001;
    localparam logic [31:0] DB = 32'hB0B0_0002;
    localparam logic [31:0] DC = 32'hC0C0_0003;

    logic [31:0] mem [0:255];
    logic [31:0] dat [0:2];

    imem_arbiter_if bus ();

    imem_arbiter #(
        .IMEM_DEPTH (256),
        .FAIR_LIMIT (4),
        .NOP_INSN   (32'h0000_0013)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ldr_op(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic exp_we,
                          input logic exp_err, input logic [31:0] exp_data);
        bus.ldr_valid = 1'b1;
        bus.ldr_we    = we;
        bus.ldr_addr  = addr;
        bus.ldr_wdata = wdata;
        #1;
        chk({tag, " ldr_ready"}, bus.ldr_ready, 1'b1);
        chk({tag, " mem_we"}, bus.mem_we, exp_we);
        tick();
        chk({tag, " rsp_valid"}, bus.ldr_rsp_valid, 1'b1);
        chk({tag, " rsp_err"}, bus.ldr_rsp_err, exp_err);
        chk({tag, " rsp_data"}, bus.ldr_rsp_data, exp_data);
        bus.ldr_valid = 1'b0;
        bus.ldr_we    = 1'b0;
    endtask

    initial begin
        dat[0] = DA; dat[1] = DB; dat[2] = DC;
        bus.fetch_valid = 1'b1;
        bus.fetch_addr  = 32'd0;
        bus.ldr_valid   = 1'b1;
        bus.ldr_we      = 1'b0;
        bus.ldr_addr    = 32'd0;
        bus.ldr_wdata   = 32'd0;
        bus.ldr_done    = 1'b0;

        #3;
        chk("rst fetch_ready", bus.fetch_ready, 1'b0);
        chk("rst ldr_ready", bus.ldr_ready, 1'b0);
        chk("rst running", bus.running, 1'b0);
        chk("rst mem_addr", bus.mem_addr, 32'd0);
        chk("rst mem_we", bus.mem_we, 1'b0);
        chk("rst fetch_rsp_valid", bus.fetch_rsp_valid, 1'b0);
        chk("rst ldr_rsp_valid", bus.ldr_rsp_valid, 1'b0);
        chk("rst ldr_rsp_data", bus.ldr_rsp_data, 32'd0);
        bus.ldr_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Boot fill while fetch is knocking
        for (int i = 0; i < 3; i++) begin
            bus.ldr_valid = 1'b1;
            bus.ldr_addr  = 32'(4 * i);
            #1;
            chk("boot fetch_ready", bus.fetch_ready, 1'b0);
            #0;
            ldr_op("boot wr", 1'b1, 32'(4 * i), dat[i], 1'b1, 1'b0, 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            ldr_op("boot rd", 1'b0, 32'(4 * i), 32'd0, 1'b0, 1'b0, dat[i]);
        end
        chk("boot fetch_rsp_valid", bus.fetch_rsp_valid, 1'b0);

        // Boot exit
        bus.fetch_valid = 1'b0;
        bus.ldr_done    = 1'b1;
        #1;
        chk("done running before", bus.running, 1'b0);
        tick();
        bus.ldr_done = 1'b0;
        chk("done running after", bus.running, 1'b1);
        bus.fetch_valid = 1'b1;
        bus.fetch_addr  = 32'h4;
        #1;
        chk("exit fetch_ready", bus.fetch_ready, 1'b1);
        chk("exit mem_addr", bus.mem_addr, 32'h4);
        tick();
        chk("exit rsp_valid", bus.fetch_rsp_valid, 1'b1);
        chk("exit rsp_data", bus.fetch_rsp_data, DB);
        chk("exit rsp_err", bus.fetch_rsp_err, 1'b0);

        // Back-to-back fetches
        for (int i = 0; i < 3; i++) begin
            bus.fetch_addr = 32'(4 * i);
            tick();
            chk("thru rsp_valid", bus.fetch_rsp_valid, 1'b1);
            chk("thru rsp_data", bus.fetch_rsp_data, dat[i]);
        end
        bus.fetch_valid = 1'b0;
        tick();
        chk("thru rsp idle", bus.fetch_rsp_valid, 1'b0);

        // Fairness: F,F,F,F,L repeating
        bus.fetch_valid = 1'b1;
        bus.fetch_addr  = 32'h0;
        bus.ldr_valid   = 1'b1;
        bus.ldr_we      = 1'b0;
        bus.ldr_addr    = 32'h8;
        for (int k = 0; k < 10; k++) begin
            logic exp_l;
            exp_l = ((k % 5) == 4);
            #1;
            chk("fair ldr_ready", bus.ldr_ready, exp_l);
            chk("fair fetch_ready", bus.fetch_ready, !exp_l);
            tick();
            chk("fair ldr_rsp_valid", bus.ldr_rsp_valid, exp_l);
            if (exp_l) chk("fair ldr_rsp_data", bus.ldr_rsp_data, DC);
        end
        bus.fetch_valid = 1'b0;
        bus.ldr_valid   = 1'b0;
        tick();

        // Error paths
        bus.fetch_valid = 1'b1;
        bus.fetch_addr  = 32'h2;
        tick();
        chk("err mis rsp_data", bus.fetch_rsp_data, 32'h0000_0013);
        chk("err mis rsp_err", bus.fetch_rsp_err, 1'b1);
        bus.fetch_addr = 32'h400;
        tick();
        chk("err oor rsp_data", bus.fetch_rsp_data, 32'h0000_0013);
        chk("err oor rsp_err", bus.fetch_rsp_err, 1'b1);
        bus.fetch_valid = 1'b0;
        ldr_op("err wr", 1'b1, 32'h400, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'd0);
        chk("err mem intact", mem[0], DA);
        ldr_op("err rdback", 1'b0, 32'h0, 32'd0, 1'b0, 1'b0, DA);

        // Reset while a response is valid
        bus.fetch_valid = 1'b1;
        bus.fetch_addr  = 32'h8;
        tick();
        chk("mid rsp_valid", bus.fetch_rsp_valid, 1'b1);
        chk("mid rsp_data", bus.fetch_rsp_data, DC);
        rst = 1'b1;
        #1;
        chk("mid async rsp_valid", bus.fetch_rsp_valid, 1'b0);
        chk("mid async running", bus.running, 1'b0);
        chk("mid async mem_addr", bus.mem_addr, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("mid boot fetch_ready", bus.fetch_ready, 1'b0);
        chk("mid boot running", bus.running, 1'b0);
        bus.fetch_valid = 1'b0;
        ldr_op("mid persist", 1'b0, 32'h4, 32'd0, 1'b0, 1'b0, DB);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
